// File: rtl/mem_io_pkg.sv
// Shared IO map and address decode for the memory/IO responder.
// Used by mem_io_responder and its testbench-visible decode.
package mem_io_pkg;

   localparam logic [31:0] IO_UART_ADDR = 32'h30000;
   localparam logic [31:0] IO_HALT_ADDR = 32'h30004;
   localparam logic [1:0]  IO_SEL_BITS  = 2'b11;

   typedef enum logic [1:0] {
      SEL_RAM,
      SEL_UART,
      SEL_HALT,
      SEL_NONE
   } sel_e;

   function automatic sel_e decode(input logic [17:0] a);
      sel_e s;
      if (a[17:16] != IO_SEL_BITS) s = SEL_RAM;
      else if (a == IO_UART_ADDR[17:0]) s = SEL_UART;
      else if (a == IO_HALT_ADDR[17:0]) s = SEL_HALT;
      else s = SEL_NONE;
      return s;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two byte FIFO with count; head is combinational.
// Push when full and pop when empty are ignored.
module byte_fifo #(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [7:0]    i_data,
   output logic [7:0]    o_head,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   assign o_head  = r_mem[r_rd];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
         else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped UART FIFOs and halt flag.
// Define MEM_IO_RX_EN to build the RX FIFO and RX read path.
module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int RAM_AW     = 17,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        halt
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    r_ram [2**RAM_AW];
   logic [7:0]    r_din;
   logic          r_halt;
   logic          r_full;
   sel_e          w_sel;
   logic          w_wr;
   logic [7:0]    w_rd_data;
   logic          w_tx_push;
   logic          w_tx_pop;
   logic          w_tx_full;
   logic          w_tx_empty;
   logic [7:0]    w_tx_head;
   logic [CW-1:0] w_tx_cnt;
   logic [CW-1:0] w_tx_cnt_nxt;
   logic [7:0]    w_rx_byte;
   logic          w_rx_nonempty;

   assign w_sel = decode(mem_a[17:0]);
   assign w_wr  = rdy && mem_wr;

   always_ff @(posedge clk) begin
      if (w_wr && w_sel == SEL_RAM) r_ram[mem_a[RAM_AW-1:0]] <= mem_dout;
   end

   assign w_tx_push = w_wr && w_sel == SEL_UART && !w_tx_full;
   assign w_tx_pop  = rdy && !w_tx_empty && tx_ready;
   assign tx_valid  = !w_tx_empty;
   assign tx_data   = w_tx_head;

   byte_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_tx_push),
      .i_pop   (w_tx_pop),
      .i_data  (mem_dout),
      .o_head  (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (w_tx_cnt)
   );

   always_comb begin
      w_tx_cnt_nxt = w_tx_cnt;
      if (w_tx_push && !w_tx_pop)      w_tx_cnt_nxt = w_tx_cnt + CW'(1);
      else if (!w_tx_push && w_tx_pop) w_tx_cnt_nxt = w_tx_cnt - CW'(1);
   end

`ifdef MEM_IO_RX_EN
   logic          w_rx_push;
   logic          w_rx_pop;
   logic          w_rx_full;
   logic          w_rx_empty;
   logic [7:0]    w_rx_head;
   logic [CW-1:0] w_unused_rx_cnt;
   logic          w_unused;

   assign rx_ready      = !w_rx_full;
   assign w_rx_push     = rdy && rx_valid && !w_rx_full;
   assign w_rx_pop      = rdy && !mem_wr && w_sel == SEL_UART && !w_rx_empty;
   assign w_rx_nonempty = !w_rx_empty;
   assign w_rx_byte     = w_rx_nonempty ? w_rx_head : 8'h00;
   assign w_unused      = ^{mem_a[31:18], w_unused_rx_cnt};

   byte_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_rx (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_rx_push),
      .i_pop   (w_rx_pop),
      .i_data  (rx_data),
      .o_head  (w_rx_head),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (w_unused_rx_cnt)
   );
`else
   logic w_unused;

   assign rx_ready      = 1'b0;
   assign w_rx_nonempty = 1'b0;
   assign w_rx_byte     = 8'h00;
   assign w_unused      = ^{mem_a[31:18], rx_data, rx_valid};
`endif

   always_comb begin
      w_rd_data = 8'h00;
      unique case (w_sel)
         SEL_RAM:  w_rd_data = r_ram[mem_a[RAM_AW-1:0]];
         SEL_UART: w_rd_data = w_rx_byte;
         SEL_HALT: w_rd_data = {7'd0, w_rx_nonempty};
         SEL_NONE: w_rd_data = 8'h00;
      endcase
   end

   // Full is flagged one entry early so a write already in flight still fits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_din  <= 8'h00;
         r_halt <= 1'b0;
         r_full <= 1'b0;
      end else if (rdy) begin
         if (!mem_wr) r_din <= w_rd_data;
         if (mem_wr && w_sel == SEL_HALT) r_halt <= 1'b1;
         r_full <= (w_tx_cnt_nxt >= CW'(FIFO_DEPTH - 1));
      end
   end

   assign mem_din        = r_din;
   assign halt           = r_halt;
   assign io_buffer_full = r_full;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder against a queue-based model.
// Follows the DUT build: MEM_IO_RX_EN selects the RX model.
module tb_mem_io_responder;

   localparam int D = 8;
`ifdef MEM_IO_RX_EN
   localparam bit RXEN = 1'b1;
`else
   localparam bit RXEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdy = 1'b0;
   logic        mem_wr = 1'b0;
   logic        tx_ready = 1'b0;
   logic        rx_valid = 1'b0;
   logic [31:0] mem_a = '0;
   logic [7:0]  mem_dout = '0;
   logic [7:0]  rx_data = '0;
   logic [7:0]  mem_din;
   logic [7:0]  tx_data;
   logic        io_buffer_full;
   logic        tx_valid;
   logic        rx_ready;
   logic        halt;

   int total = 0;
   int bad = 0;

   logic [7:0] mram [int];
   logic [7:0] mtx[$];
   logic [7:0] mrx[$];
   logic [7:0] sb_tx[$];
   logic [7:0] sb_rd[$];
   logic       m_halt = 1'b0;
   logic       m_full = 1'b0;
   logic [7:0] m_din = 8'h00;
   bit         rd_evt = 1'b0;
   logic [31:0] pool [16];

   mem_io_responder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rdy            (rdy),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .mem_dout       (mem_dout),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .halt           (halt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, then check outputs.
   task automatic step(input logic rs, input logic r, input logic wr,
                       input logic [31:0] a, input logic [7:0] d,
                       input logic txr, input logic rxv,
                       input logic [7:0] rxd);
      logic io, uart, hlt, txpop, txpush, rxpush, rxpop;
      logic [7:0] ev;
      rst_n = rs; rdy = r; mem_wr = wr; mem_a = a; mem_dout = d;
      tx_ready = txr; rx_valid = rxv; rx_data = rxd;
      io   = (a[17:16] == 2'b11);
      uart = io && (a[17:0] == 18'h30000);
      hlt  = io && (a[17:0] == 18'h30004);
      if (!rs) begin
         m_din = 8'h00; m_halt = 1'b0; m_full = 1'b0;
         mtx.delete(); mrx.delete();
      end else if (r) begin
         txpop  = (mtx.size() > 0) && txr;
         txpush = wr && uart && (mtx.size() < D);
         rxpush = RXEN && rxv && (mrx.size() < D);
         rxpop  = RXEN && !wr && uart && (mrx.size() > 0);
         if (!wr) begin
            if (!io) ev = mram.exists(int'(a[16:0])) ? mram[int'(a[16:0])] : 8'h00;
            else if (uart) ev = rxpop ? mrx[0] : 8'h00;
            else if (hlt) ev = {7'd0, mrx.size() > 0};
            else ev = 8'h00;
            m_din = ev;
            sb_rd.push_back(ev);
         end
         if (wr && !io) mram[int'(a[16:0])] = d;
         if (wr && hlt) m_halt = 1'b1;
         if (txpop) void'(mtx.pop_front());
         if (txpush) begin mtx.push_back(d); sb_tx.push_back(d); end
         if (rxpop) void'(mrx.pop_front());
         if (rxpush) mrx.push_back(rxd);
         m_full = (mtx.size() >= D - 1);
      end
      @(posedge clk); #1;
      if (!rs) begin sb_tx.delete(); sb_rd.delete(); end
      chk("mem_din", mem_din, m_din);
      chk("halt", halt, m_halt);
      chk("io_buffer_full", io_buffer_full, m_full);
      chk("tx_valid", tx_valid, mtx.size() > 0);
      chk("rx_ready", rx_ready, RXEN && (mrx.size() < D));
   endtask

   // Write to an unmapped IO address: a cycle with no side effects.
   task automatic idle(input int n, input logic txr);
      for (int i = 0; i < n; i++) step(1, 1, 1, 32'h30008, 8'hEE, txr, 0, 8'h00);
   endtask

   always @(posedge clk) rd_evt = (rst_n === 1'b1 && rdy === 1'b1 && mem_wr === 1'b0);

   always @(negedge clk) begin
      if (rd_evt) begin
         if (sb_rd.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_sb: read data with no expectation, got %0h", mem_din);
         end else chk("rd_data", mem_din, sb_rd.pop_front());
      end
      if (rst_n === 1'b1 && rdy === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
         if (sb_tx.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_sb: unexpected tx byte %0h", tx_data);
         end else chk("tx_data", tx_data, sb_tx.pop_front());
      end
   end

   initial begin
      logic [31:0] a, up;
      int k;
      step(0, 0, 0, 32'h0, 8'h00, 0, 0, 8'h00);
      step(0, 1, 0, 32'h0, 8'h00, 0, 0, 8'h00);
      chk("reset_din", mem_din, 8'h00);
      chk("reset_txv", tx_valid, 1'b0);

      step(1, 1, 1, 32'h10, 8'hA5, 0, 0, 8'h00);
      step(1, 1, 0, 32'h10, 8'h00, 0, 0, 8'h00);
      chk("ram_a5", mem_din, 8'hA5);

      for (int i = 0; i < 9; i++) begin
         step(1, 1, 1, 32'h30000, 8'h10 + 8'(i), 0, 0, 8'h00);
         if (i == 5) chk("full_after6", io_buffer_full, 1'b0);
         if (i == 6) chk("full_after7", io_buffer_full, 1'b1);
      end
      idle(10, 1);
      chk("tx_drained", tx_valid, 1'b0);

      step(1, 1, 1, 32'h30004, 8'h00, 0, 0, 8'h00);
      chk("halt_set", halt, 1'b1);
      idle(100, 0);
      chk("halt_hold", halt, 1'b1);
      step(0, 1, 0, 32'h0, 8'h00, 0, 0, 8'h00);
      chk("halt_clr", halt, 1'b0);

      step(1, 1, 1, 32'h30008, 8'h00, 0, 1, 8'h41);
      step(1, 1, 1, 32'h30008, 8'h00, 0, 1, 8'h42);
      step(1, 1, 0, 32'h30004, 8'h00, 0, 0, 8'h00);
      chk("rx_status", mem_din, {7'd0, RXEN});
      step(1, 1, 0, 32'h30000, 8'h00, 0, 0, 8'h00);
      chk("rx_first", mem_din, RXEN ? 8'h41 : 8'h00);
      step(1, 1, 0, 32'h30000, 8'h00, 0, 0, 8'h00);
      chk("rx_second", mem_din, RXEN ? 8'h42 : 8'h00);
      step(1, 1, 0, 32'h30000, 8'h00, 0, 0, 8'h00);
      chk("rx_empty", mem_din, 8'h00);

      step(1, 1, 1, 32'h30000, 8'h61, 0, 0, 8'h00);
      step(1, 1, 1, 32'h30000, 8'h62, 0, 0, 8'h00);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h10, 8'h5A, 1, 1, 8'h99);
      chk("frz_txv", tx_valid, 1'b1);
      step(1, 1, 0, 32'h10, 8'h00, 0, 0, 8'h00);
      chk("frz_ram", mem_din, 8'hA5);
      idle(4, 1);

      for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h30000, 8'h70 + 8'(i), 0, 0, 8'h00);
      step(0, 1, 0, 32'h0, 8'h00, 0, 0, 8'h00);
      chk("rst_drop_tx", tx_valid, 1'b0);
      idle(5, 1);

      for (int i = 0; i < 16; i++) begin
         pool[i] = 32'($urandom_range(0, 32'h2FFFF));
         step(1, 1, 1, pool[i], 8'($urandom), 0, 0, 8'h00);
      end
      for (int n = 0; n < 3000; n++) begin
         k  = $urandom_range(0, 99);
         up = $urandom & 32'hFFFC0000;
         a  = up | 32'h30008;
         if (k < 25) step(1, $urandom_range(0, 9) != 0, 1, up | pool[$urandom_range(0, 15)],
                          8'($urandom), $urandom_range(0, 1), $urandom_range(0, 2) == 0, 8'($urandom));
         else if (k < 50) step($urandom_range(0, 299) != 0, $urandom_range(0, 9) != 0, 0,
                          up | pool[$urandom_range(0, 15)], 8'h00, $urandom_range(0, 1),
                          $urandom_range(0, 2) == 0, 8'($urandom));
         else begin
            if (k < 65) a = up | 32'h30000;
            else if (k < 80) a = up | 32'h30000;
            else if (k < 91) a = up | 32'h30004;
            else a = up | (32'h30000 + 32'($urandom_range(2, 15)) * 4);
            step(1, $urandom_range(0, 9) != 0, (k < 65) || (k == 90) || (k > 95),
                 a, 8'($urandom), $urandom_range(0, 1), $urandom_range(0, 2) == 0, 8'($urandom));
         end
      end
      idle(2 * D + 4, 1);
      chk("tx_sb_left", sb_tx.size(), 0);
      chk("rd_sb_left", sb_rd.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
